reg_operand_fetch: RTL and testbench

//  Initiator side of the register-file port: sequences operand reads, drives writebacks, and tracks in-flight destination registers.

---
 rtl/reg_operand_fetch.sv | 140 ++++++++++++++
 tb/tb_reg_operand_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_operand_fetch.sv
// reg_operand_fetch: register-file initiator between decode and execute. Reads
//   rs1/rs2 for one instruction at a time, hands the operands to execute, drives
//   writebacks, and keeps a per-register pending scoreboard for RAW/WAW stalls.
// Latency: accept edge E0 -> op_valid high after E1; peak 1 instruction / 3 cycles.
// Backpressure: issue_ready low on hazard or while busy; op_* hold until op_ready;
//   the writeback port never stalls (wb_ready tied high).
// Ports: issue_* decode side, op_* execute side, wb_* writeback requests,
//   rf_* register file read/write port, sb_pending/wb_err scoreboard status.
module reg_operand_fetch #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 32,
  parameter int REG_SIZE   = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_SIZE-1:0]   issue_rs1,
  input  logic [REG_SIZE-1:0]   issue_rs2,
  input  logic [REG_SIZE-1:0]   issue_rd,
  input  logic                  issue_rd_wr,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [REG_SIZE-1:0]   op_rd,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_SIZE-1:0]   wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [REG_SIZE-1:0]   rf_rs1,
  output logic [REG_SIZE-1:0]   rf_rs2,
  input  logic [DATA_WIDTH-1:0] rf_regA,
  input  logic [DATA_WIDTH-1:0] rf_regB,
  output logic                  rf_wen,
  output logic [REG_SIZE-1:0]   rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  output logic [REG_COUNT-1:0]  sb_pending,
  output logic                  wb_err
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t               state, state_nxt;
  logic [REG_SIZE-1:0]  rs1_q, rs2_q, rd_q;
  logic                 hazard;
  logic                 accept;
  logic                 wb_live;
  logic                 clr_vld;
  logic [REG_SIZE-1:0]  clr_rd;
  logic [REG_COUNT-1:0] sb_nxt;

  // Writeback goes straight through to the register file; r0 writes are dropped.
  assign wb_live    = wb_valid && (wb_rd != '0);
  assign wb_ready   = 1'b1;
  assign rf_wen     = wb_live;
  assign rf_rd      = wb_rd;
  assign rf_data_in = wb_data;

  // r0 is never pending. A register whose clear is still in its settle cycle is
  // still marked pending, so dependent issues naturally stall for that cycle.
  assign hazard = ((issue_rs1 != '0) && sb_pending[issue_rs1]) ||
                  ((issue_rs2 != '0) && sb_pending[issue_rs2]) ||
                  (issue_rd_wr && (issue_rd != '0) && sb_pending[issue_rd]);

  assign accept = (state == IDLE) && issue_valid && !hazard;

  always_comb begin
    state_nxt   = state;
    issue_ready = 1'b0;
    rf_rs1      = rs1_q;
    rf_rs2      = rs2_q;
    case (state)
      IDLE: begin
        // Present the incoming indices so read data is ready during READ.
        rf_rs1      = issue_rs1;
        rf_rs2      = issue_rs2;
        issue_ready = !hazard;
        if (issue_valid && !hazard) state_nxt = READ;
      end
      READ:    state_nxt = HOLD;
      HOLD:    if (op_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_rd    <= '0;
    end else begin
      if (accept) begin
        rs1_q <= issue_rs1;
        rs2_q <= issue_rs2;
        rd_q  <= issue_rd;
      end
      if (state == READ) begin
        op_a     <= rf_regA;
        op_b     <= rf_regB;
        op_rd    <= rd_q;
        op_valid <= 1'b1;
      end else if ((state == HOLD) && op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

  // Clear is delayed one cycle behind rf_wen to cover the register file's
  // commit latency. WAW stalling guarantees a set and clear never hit the same bit.
  always_comb begin
    sb_nxt = sb_pending;
    if (clr_vld) sb_nxt[clr_rd] = 1'b0;
    if (accept && issue_rd_wr && (issue_rd != '0)) sb_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sb_pending <= '0;
      clr_vld    <= 1'b0;
      clr_rd     <= '0;
      wb_err     <= 1'b0;
    end else begin
      sb_pending <= sb_nxt;
      clr_vld    <= wb_live;
      clr_rd     <= wb_rd;
      if (wb_live && !sb_pending[wb_rd]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_operand_fetch.sv
`timescale 1ns/1ps
module tb_reg_operand_fetch;
  localparam int DW = 16;
  localparam int RC = 32;
  localparam int RS = 5;

  logic          clk = 1'b0;
  logic          rstN;
  logic          issue_valid, issue_ready, issue_rd_wr;
  logic [RS-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic [RS-1:0] op_rd;
  logic          wb_valid, wb_ready;
  logic [RS-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [RS-1:0] rf_rs1, rf_rs2, rf_rd;
  logic [DW-1:0] rf_regA, rf_regB, rf_data_in;
  logic          rf_wen;
  logic [RC-1:0] sb_pending;
  logic          wb_err;

  reg_operand_fetch #(.DATA_WIDTH(DW), .REG_COUNT(RC), .REG_SIZE(RS)) dut (
    .clk(clk), .rstN(rstN),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_rd_wr(issue_rd_wr),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_regA(rf_regA), .rf_regB(rf_regB),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data_in(rf_data_in),
    .sb_pending(sb_pending), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Register file: registered read, write committed one cycle after rf_wen.
  logic [DW-1:0] rf_mem [RC];
  logic          rf_init;
  logic          cm_vld;
  logic [RS-1:0] cm_rd;
  logic [DW-1:0] cm_dat;
  always @(posedge clk) begin
    if (rf_init !== 1'b1) begin
      for (int i = 0; i < RC; i++) rf_mem[i] <= '0;
      rf_init <= 1'b1;
    end else if (cm_vld === 1'b1) begin
      rf_mem[cm_rd] <= cm_dat;
    end
    rf_regA <= rf_mem[rf_rs1];
    rf_regB <= rf_mem[rf_rs2];
    cm_vld  <= rf_wen;
    cm_rd   <= rf_rd;
    cm_dat  <= rf_data_in;
  end

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RS-1:0] rd;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  logic [DW-1:0] ref_regs [RC];
  int            vectors = 0;
  int            miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one writeback beat and updates the architectural reference.
  task automatic wb_drive(input logic [RS-1:0] rd, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = d;
    if (rd != '0) ref_regs[rd] = d;
  endtask

  // Holds an instruction until accepted; returns #1 after the accept edge.
  task automatic do_issue(input logic [RS-1:0] s1, input logic [RS-1:0] s2,
                          input logic [RS-1:0] d, input logic w, input int budget);
    bit ok;
    ok = 1'b0;
    issue_valid = 1'b1; issue_rs1 = s1; issue_rs2 = s2; issue_rd = d; issue_rd_wr = w;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (issue_ready) begin
        ok = 1'b1;
        exp_q.push_back('{a: ref_regs[s1], b: ref_regs[s2], rd: d});
      end
      tick();
    end
    issue_valid = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: accepted=0 required=1 (rs1=%0d rs2=%0d rd=%0d)", s1, s2, d);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; issue_valid = 0; issue_rs1 = 5'd3; issue_rs2 = 5'd4; issue_rd = 0;
    issue_rd_wr = 0; op_ready = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    #12;
    vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL rst_op_valid: got %b want 0", op_valid); end
    vectors++; if (sb_pending !== '0) begin miscompares++; $display("FAIL rst_sb: got %h want 0", sb_pending); end
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("FAIL rst_wb_err: got %b want 0", wb_err); end
    vectors++; if ({op_a, op_b, op_rd} !== '0) begin miscompares++; $display("FAIL rst_op_data: got %h/%h/%0d want 0", op_a, op_b, op_rd); end
    vectors++; if (rf_rs1 !== 5'd3 || rf_rs2 !== 5'd4) begin miscompares++; $display("FAIL rst_rf_idx: got %0d/%0d want 3/4", rf_rs1, rf_rs2); end
    vectors++; if (issue_ready !== 1'b1 || wb_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b/%b want 1/1", issue_ready, wb_ready); end
    @(negedge clk); rstN = 1'b1;
    tick();
    // Preload r5/r6; these writes target non-pending registers.
    wb_drive(5'd5, 16'h1234);
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_data_in !== 16'h1234) begin miscompares++; $display("FAIL preload_wb: got wen=%b rd=%0d d=%h want 1/5/1234", rf_wen, rf_rd, rf_data_in); end
    tick();
    wb_drive(5'd6, 16'h00FF);
    tick();
    wb_valid = 1'b0;
    tick(); tick();
    vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("FAIL preload_wb_err: got %b want 1", wb_err); end
    @(negedge clk); rstN = 1'b0;
    #1;
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("FAIL rst_clears_err: got %b want 0", wb_err); end
    @(negedge clk); rstN = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_issue(5'd5, 5'd6, 5'd7, 1'b1, 4);
    issue_rs1 = 5'd31; issue_rs2 = 5'd30;
    @(negedge clk);
    vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL basic_read_valid: got %b want 0", op_valid); end
    vectors++; if (sb_pending !== 32'h0000_0080) begin miscompares++; $display("FAIL basic_sb7: got %h want 00000080", sb_pending); end
    vectors++; if (rf_rs1 !== 5'd5 || rf_rs2 !== 5'd6) begin miscompares++; $display("FAIL basic_latched_idx: got %0d/%0d want 5/6", rf_rs1, rf_rs2); end
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL basic_read_ready: got %b want 0", issue_ready); end
    tick();
    @(negedge clk);
    vectors++; if (op_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", op_valid); end
    e = exp_q.pop_front();
    vectors++; if (op_a !== e.a || op_a !== 16'h1234) begin miscompares++; $display("FAIL basic_op_a: got %h want 1234", op_a); end
    vectors++; if (op_b !== e.b || op_b !== 16'h00FF) begin miscompares++; $display("FAIL basic_op_b: got %h want 00ff", op_b); end
    vectors++; if (op_rd !== e.rd) begin miscompares++; $display("FAIL basic_op_rd: got %0d want %0d", op_rd, e.rd); end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic test_raw();
    // r7 is still pending from the previous instruction.
    issue_valid = 1'b1; issue_rs1 = 5'd7; issue_rs2 = 5'd6; issue_rd = 5'd8; issue_rd_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall%0d: got %b want 0", i, issue_ready); end
      tick();
    end
    wb_drive(5'd7, 16'hABCD);
    @(negedge clk);
    vectors++; if (issue_ready !== 1'b0 || rf_wen !== 1'b1) begin miscompares++; $display("FAIL raw_wb_cycle: ready=%b wen=%b want 0/1", issue_ready, rf_wen); end
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    vectors++; if (issue_ready !== 1'b0 || sb_pending[7] !== 1'b1) begin miscompares++; $display("FAIL raw_settle: ready=%b pend7=%b want 0/1", issue_ready, sb_pending[7]); end
    tick();
    @(negedge clk);
    vectors++; if (issue_ready !== 1'b1 || sb_pending[7] !== 1'b0) begin miscompares++; $display("FAIL raw_release: ready=%b pend7=%b want 1/0", issue_ready, sb_pending[7]); end
    if (issue_ready) exp_q.push_back('{a: ref_regs[7], b: ref_regs[6], rd: 5'd8});
    tick();
    issue_valid = 1'b0;
    tick();
    @(negedge clk);
    vectors++; if (op_valid !== 1'b1 || exp_q.size() == 0) begin miscompares++; $display("FAIL raw_valid: got %b qsize=%0d want 1", op_valid, exp_q.size()); end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      vectors++; if (op_a !== 16'hABCD || op_b !== e.b || op_rd !== e.rd) begin miscompares++; $display("FAIL raw_operands: got %h/%h/%0d want abcd/%h/%0d", op_a, op_b, op_rd, e.b, e.rd); end
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
  endtask

  task automatic test_hold();
    do_issue(5'd5, 5'd6, 5'd0, 1'b0, 4);
    tick();
    issue_valid = 1'b1; issue_rs1 = 5'd1; issue_rs2 = 5'd2; issue_rd = 5'd3; issue_rd_wr = 1'b0;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) wb_drive(5'd8, 16'h5A5A);
      if (i == 3) wb_valid = 1'b0;
      @(negedge clk);
      vectors++; if (op_valid !== 1'b1 || op_a !== e.a || op_b !== e.b || issue_ready !== 1'b0) begin miscompares++; $display("FAIL hold%0d: valid=%b a=%h b=%h ready=%b want 1/%h/%h/0", i, op_valid, op_a, op_b, issue_ready, e.a, e.b); end
      if (i == 2) begin
        vectors++; if (rf_wen !== 1'b1 || rf_rd !== 5'd8 || rf_data_in !== 16'h5A5A) begin miscompares++; $display("FAIL hold_wb: wen=%b rd=%0d d=%h want 1/8/5a5a", rf_wen, rf_rd, rf_data_in); end
      end
      tick();
    end
    op_ready = 1'b1; issue_valid = 1'b0;
    tick();
    op_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk);
    vectors++; if (op_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: got %b want 0", op_valid); end
    tick();
  endtask

  task automatic test_zero();
    do_issue(5'd0, 5'd0, 5'd0, 1'b1, 4);
    @(negedge clk);
    vectors++; if (sb_pending !== '0) begin miscompares++; $display("FAIL zero_sb: got %h want 0", sb_pending); end
    tick();
    @(negedge clk);
    vectors++; if (op_valid !== 1'b1 || op_a !== 16'h0 || op_b !== 16'h0) begin miscompares++; $display("FAIL zero_ops: valid=%b a=%h b=%h want 1/0/0", op_valid, op_a, op_b); end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    wb_drive(5'd0, 16'hFFFF);
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL zero_wen: got %b want 0", rf_wen); end
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("FAIL zero_err: got %b want 0", wb_err); end
    tick();
  endtask

  task automatic test_err_reset();
    wb_drive(5'd9, 16'h0909);
    @(negedge clk);
    vectors++; if (rf_wen !== 1'b1 || wb_err !== 1'b0) begin miscompares++; $display("FAIL err_wb: wen=%b err=%b want 1/0", rf_wen, wb_err); end
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    vectors++; if (wb_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b want 1", wb_err); end
    tick(); tick();
    do_issue(5'd9, 5'd5, 5'd10, 1'b1, 4);
    #2;
    rstN = 1'b0;
    #1;
    vectors++; if (op_valid !== 1'b0 || sb_pending !== '0 || wb_err !== 1'b0) begin miscompares++; $display("FAIL midread_reset: valid=%b sb=%h err=%b want 0/0/0", op_valid, sb_pending, wb_err); end
    exp_q.delete();
    @(negedge clk); rstN = 1'b1;
    tick(); tick();
    @(negedge clk);
    vectors++; if (op_valid !== 1'b0 || issue_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle: valid=%b ready=%b want 0/1", op_valid, issue_ready); end
    tick();
  endtask

  task automatic test_random();
    logic [RC-1:0] tb_pend;
    logic [RS-1:0] out_q[$];
    logic [RS-1:0] r, prev_rd, this_rd;
    logic          prev_wb, this_wb, hz, acc, exp_rdy;
    int            tb_state, ops_done, cyc, k;
    tb_pend = '0; prev_wb = 0; prev_rd = 0; tb_state = 0; ops_done = 0; cyc = 0;
    while (ops_done < 200 && cyc < 20000) begin
      cyc++;
      if (!issue_valid && $urandom_range(0, 3) != 0) begin
        issue_valid = 1'b1;
        issue_rs1   = RS'($urandom_range(0, 7));
        issue_rs2   = RS'($urandom_range(0, 7));
        issue_rd    = RS'($urandom_range(0, 7));
        issue_rd_wr = 1'($urandom_range(0, 1));
      end
      this_wb = 1'b0; this_rd = '0;
      if (out_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, out_q.size() - 1);
        r = out_q[k];
        out_q.delete(k);
        wb_drive(r, DW'($urandom));
        this_wb = 1'b1; this_rd = r;
      end else begin
        wb_valid = 1'b0;
      end
      op_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      hz = tb_pend[issue_rs1] | tb_pend[issue_rs2] | (issue_rd_wr & tb_pend[issue_rd]);
      vectors++; if (sb_pending !== tb_pend) begin miscompares++; $display("FAIL rnd_sb c%0d: got %h want %h", cyc, sb_pending, tb_pend); end
      vectors++; if (op_valid !== (tb_state == 2)) begin miscompares++; $display("FAIL rnd_op_valid c%0d: got %b want %b", cyc, op_valid, tb_state == 2); end
      if (issue_valid) begin
        exp_rdy = (tb_state == 0) && !hz;
        vectors++; if (issue_ready !== exp_rdy) begin miscompares++; $display("FAIL rnd_issue_ready c%0d: got %b want %b", cyc, issue_ready, exp_rdy); end
      end
      acc = issue_valid && issue_ready;
      if (op_valid && op_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL rnd_unexpected_op c%0d: got op_valid=1 want no output", cyc);
        end else begin
          e = exp_q.pop_front();
          if (op_a !== e.a || op_b !== e.b || op_rd !== e.rd) begin miscompares++; $display("FAIL rnd_operands c%0d: got %h/%h/%0d want %h/%h/%0d", cyc, op_a, op_b, op_rd, e.a, e.b, e.rd); end
        end
        ops_done++;
      end
      if (acc) exp_q.push_back('{a: ref_regs[issue_rs1], b: ref_regs[issue_rs2], rd: issue_rd});
      if (prev_wb) tb_pend[prev_rd] = 1'b0;
      if (acc && issue_rd_wr && issue_rd != '0) begin
        tb_pend[issue_rd] = 1'b1;
        out_q.push_back(issue_rd);
      end
      prev_wb = this_wb; prev_rd = this_rd;
      if (tb_state == 0 && acc)                 tb_state = 1;
      else if (tb_state == 1)                   tb_state = 2;
      else if (tb_state == 2 && op_ready)       tb_state = 0;
      tick();
      if (acc) issue_valid = 1'b0;
    end
    wb_valid = 1'b0; issue_valid = 1'b0; op_ready = 1'b0;
    vectors++; if (ops_done < 200) begin miscompares++; $display("FAIL rnd_timeout: got %0d ops want 200", ops_done); end
    @(negedge clk);
    vectors++; if (wb_err !== 1'b0) begin miscompares++; $display("FAIL rnd_wb_err: got %b want 0", wb_err); end
  endtask

  initial begin
    for (int i = 0; i < RC; i++) ref_regs[i] = '0;
    test_reset();
    test_basic();
    test_raw();
    test_hold();
    test_zero();
    test_err_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
